// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - Shared opcodes, flag indices, issue FSM states and op decode for the FPU front end
package fpu_pkg;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [4:0] OP_FADD   = 5'd0;
    localparam logic [4:0] OP_FSUB   = 5'd1;
    localparam logic [4:0] OP_FMUL   = 5'd2;
    localparam logic [4:0] OP_FDIV   = 5'd3;
    localparam logic [4:0] OP_FSQRT  = 5'd4;
    localparam logic [4:0] OP_FMADD  = 5'd5;
    localparam logic [4:0] OP_FMSUB  = 5'd6;
    localparam logic [4:0] OP_FNMSUB = 5'd7;
    localparam logic [4:0] OP_FNMADD = 5'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } fpu_state_t;

    // Only the fused multiply-add family reads the third operand.
    function automatic logic is_fma_op(input logic [4:0] op);
        return (op == OP_FMADD) || (op == OP_FMSUB) || (op == OP_FNMSUB) || (op == OP_FNMADD);
    endfunction

endpackage

// File: rtl/fpu_op_fifo.sv
// rtl/fpu_op_fifo.sv - Op queue for the FPU issue buffer: pointer+wrap FIFO with sync clear
module fpu_op_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_tvalid,
    output logic             wr_tready,
    input  logic [WIDTH-1:0] wr_tdata,
    output logic             rd_tvalid,
    input  logic             rd_tready,
    output logic [WIDTH-1:0] rd_tdata
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign wr_tready = !full;
    assign rd_tvalid = !empty;
    assign rd_tdata  = mem[rd_ptr[AW-1:0]];
    assign push      = wr_tvalid && !full && !clear;
    assign pop       = rd_tready && !empty && !clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_tdata;
    end

endmodule

// File: rtl/fpu_issue_buffer.sv
// rtl/fpu_issue_buffer.sv - Queues FPU ops, issues them one at a time to the core, returns tagged results
module fpu_issue_buffer
    import fpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int OP_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [2:0]       in_rm,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [XLEN-1:0]  in_c,
    input  logic             in_rs2_lsb,
    input  logic [TAG_W-1:0] in_tag,
    output logic             core_start,
    output logic [OP_W-1:0]  core_op,
    output logic [2:0]       core_rm,
    output logic [XLEN-1:0]  core_a,
    output logic [XLEN-1:0]  core_b,
    output logic [XLEN-1:0]  core_c,
    output logic             core_rs2_lsb,
    input  logic [XLEN-1:0]  core_result,
    input  logic             core_done,
    input  logic [4:0]       core_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_flags,
    output logic [4:0]       fflags,
    input  logic             fflags_clr
);

    localparam int ENTRY_W = OP_W + 3 + 3 * XLEN + 1 + TAG_W;

    fpu_state_t         state_q;
    fpu_state_t         state_d;
    logic               kill_q;
    logic               kill_d;
    logic               pop;
    logic               capture;
    logic               handshake;
    logic               fifo_rd_tvalid;
    logic [ENTRY_W-1:0] fifo_rd_tdata;
    logic [OP_W-1:0]    head_op;
    logic [2:0]         head_rm;
    logic [XLEN-1:0]    head_a;
    logic [XLEN-1:0]    head_b;
    logic [XLEN-1:0]    head_c;
    logic               head_rs2_lsb;
    logic [TAG_W-1:0]   head_tag;
    logic [TAG_W-1:0]   held_tag;

    fpu_op_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_op_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .wr_tvalid (in_valid),
        .wr_tready (in_ready),
        .wr_tdata  ({in_op, in_rm, in_a, in_b, in_c, in_rs2_lsb, in_tag}),
        .rd_tvalid (fifo_rd_tvalid),
        .rd_tready (pop),
        .rd_tdata  (fifo_rd_tdata)
    );

    assign {head_op, head_rm, head_a, head_b, head_c, head_rs2_lsb, head_tag} = fifo_rd_tdata;

    assign core_start = (state_q == ST_ISSUE);
    assign out_valid  = (state_q == ST_RESP);
    assign handshake  = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    // IDLE is only reachable once the result slot is empty, so issue never overtakes a pending result.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        pop     = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (fifo_rd_tvalid && !flush) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                if (flush) kill_d = 1'b1;
            end
            ST_WAIT: begin
                // The core cannot abort, so a flushed op is drained and its result dropped.
                if (core_done) begin
                    kill_d = 1'b0;
                    if (kill_q || flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        capture = 1'b1;
                        state_d = ST_RESP;
                    end
                end else if (flush) begin
                    kill_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (flush || out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_op      <= '0;
            core_rm      <= '0;
            core_a       <= '0;
            core_b       <= '0;
            core_c       <= '0;
            core_rs2_lsb <= 1'b0;
            held_tag     <= '0;
        end else if (pop) begin
            core_op      <= head_op;
            core_rm      <= head_rm;
            core_a       <= head_a;
            core_b       <= head_b;
            core_c       <= head_c;
            core_rs2_lsb <= head_rs2_lsb;
            held_tag     <= head_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
        end else if (capture) begin
            out_result <= core_result;
            out_tag    <= held_tag;
            out_flags  <= core_flags;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fflags <= '0;
        end else if (fflags_clr) begin
            fflags <= handshake ? out_flags : 5'd0;
        end else if (handshake) begin
            fflags <= fflags | out_flags;
        end
    end

endmodule

// File: tb/tb_fpu_issue_buffer.sv
// tb/tb_fpu_issue_buffer.sv - Self-checking bench for fpu_issue_buffer with a behavioural core and result scoreboard
module tb_fpu_issue_buffer;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [2:0]  in_rm;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_c;
    logic        in_rs2_lsb;
    logic [4:0]  in_tag;
    logic        core_start;
    logic [4:0]  core_op;
    logic [2:0]  core_rm;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [31:0] core_c;
    logic        core_rs2_lsb;
    logic [31:0] core_result;
    logic        core_done;
    logic [4:0]  core_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic [4:0]  out_flags;
    logic [4:0]  fflags;
    logic        fflags_clr;

    fpu_issue_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rm        (in_rm),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_c         (in_c),
        .in_rs2_lsb   (in_rs2_lsb),
        .in_tag       (in_tag),
        .core_start   (core_start),
        .core_op      (core_op),
        .core_rm      (core_rm),
        .core_a       (core_a),
        .core_b       (core_b),
        .core_c       (core_c),
        .core_rs2_lsb (core_rs2_lsb),
        .core_result  (core_result),
        .core_done    (core_done),
        .core_flags   (core_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_tag      (out_tag),
        .out_flags    (out_flags),
        .fflags       (fflags),
        .fflags_clr   (fflags_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] result;
        logic [4:0]  flags;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          start_count = 0;
    int          core_lat = 3;
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_result = '0;
    logic        ready_level = 1'b0;
    logic        rand_ready = 1'b0;
    logic [4:0]  mdl_fflags = '0;
    logic        ff_chk = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in for the arithmetic core: any deterministic mix of all operand fields will do.
    function automatic logic [31:0] fake_core(input logic [4:0] op, input logic [2:0] rm,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic rs2);
        return (a + b) ^ (c << 1) ^ {rm, 24'd0, op} ^ {31'd0, rs2};
    endfunction

    // Behavioural core: latches the held operands at start, answers core_lat cycles later.
    initial begin
        logic [4:0]  cap_op;
        logic [2:0]  cap_rm;
        logic [31:0] cap_a, cap_b, cap_c;
        logic        cap_rs2;
        int          cnt;
        logic        busy;
        core_done = 1'b0; core_result = '0; core_flags = '0; busy = 1'b0; cnt = 0;
        cap_op = '0; cap_rm = '0; cap_a = '0; cap_b = '0; cap_c = '0; cap_rs2 = 1'b0;
        forever begin
            @(posedge clk); #1;
            core_done = 1'b0;
            if (busy) begin
                if (cnt <= 1) begin
                    core_done   = 1'b1;
                    core_result = fixed_en ? fixed_result
                                           : fake_core(cap_op, cap_rm, cap_a, cap_b, cap_c, cap_rs2);
                    core_flags  = cap_a[4:0];
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (core_start && reset) begin
                start_count++;
                busy = 1'b1; cnt = core_lat;
                cap_op = core_op; cap_rm = core_rm; cap_a = core_a; cap_b = core_b;
                cap_c = core_c; cap_rs2 = core_rs2_lsb;
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_level;
        end
    end

    // Scoreboard: accepted ops in order, dropped on flush/reset; sticky flags from delivered results.
    initial begin
        exp_t e;
        logic hs;
        forever begin
            @(negedge clk);
            if (ff_chk) check("fflags", fflags, mdl_fflags);
            ff_chk = 1'b0;
            if (!reset) begin
                exp_q.delete();
                mdl_fflags = '0;
            end else begin
                hs = out_valid && out_ready;
                e = '{tag: '0, result: '0, flags: '0};
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        check("orphan_out_valid", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_tag", out_tag, e.tag);
                        check("out_result", out_result, e.result);
                        check("out_flags", out_flags, e.flags);
                    end
                end
                if (fflags_clr) mdl_fflags = hs ? e.flags : 5'd0;
                else if (hs) mdl_fflags = mdl_fflags | e.flags;
                ff_chk = hs || fflags_clr;
                if (flush) begin
                    exp_q.delete();
                end else if (in_valid && in_ready) begin
                    exp_q.push_back('{tag: in_tag,
                                      result: fixed_en ? fixed_result
                                                       : fake_core(in_op, in_rm, in_a, in_b, in_c, in_rs2_lsb),
                                      flags: in_a[4:0]});
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Caller must be just after a rising edge; returns just after the accepting edge.
    task automatic push_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [4:0] tag);
        int n;
        in_valid = 1'b1; in_op = op; in_rm = 3'($urandom); in_a = a; in_b = b; in_c = c;
        in_rs2_lsb = 1'($urandom); in_tag = tag;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("push_accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_sig_start();
        int n;
        n = 0;
        @(negedge clk);
        while (!core_start && n < 100) begin @(negedge clk); n++; end
        check("start_seen", core_start, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n, s0;
        logic any_v;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_rm = '0; in_a = '0;
        in_b = '0; in_c = '0; in_rs2_lsb = 1'b0; in_tag = '0; fflags_clr = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_a", core_a, 0);
        check("rst_fflags", fflags, 0);
        #1 reset = 1'b1;

        // Single FADD: start two cycles after push, result the cycle after done.
        fixed_en = 1'b1; fixed_result = 32'h4040_0000; core_lat = 10;
        sync();
        s0 = start_count;
        push_op(OP_FADD, 32'h3F80_0000, 32'h4000_0000, 32'h0, 5'd3);
        @(negedge clk); check("fadd_start_n1", core_start, 0);
        @(negedge clk); check("fadd_start_n2", core_start, 1);
        n = 0;
        @(negedge clk);
        while (!core_done && n < 100) begin @(negedge clk); n++; end
        check("fadd_done_seen", core_done, 1);
        check("fadd_out_early", out_valid, 0);
        @(negedge clk);
        check("fadd_out_valid", out_valid, 1);
        check("fadd_result", out_result, 32'h4040_0000);
        check("fadd_tag", out_tag, 5'd3);
        check("fadd_flags", out_flags, 5'd0);
        check("fadd_starts", start_count - s0, 1);
        ready_level = 1'b1;
        wait_drain();
        fixed_en = 1'b0;

        // Result slot held: queue fills to DEPTH, no further issue, operands held.
        ready_level = 1'b0; core_lat = 2;
        sync();
        s0 = start_count;
        push_op(OP_FMUL, 32'h1234_5670, 32'h0BAD_F00D, 32'h0, 5'd31);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        check("blk_valid", out_valid, 1);
        sync();
        for (int t = 0; t < 4; t++) push_op(5'($urandom_range(0, 8)), $urandom, $urandom, $urandom, 5'(t));
        in_valid = 1'b1; in_op = OP_FSUB; in_a = $urandom; in_tag = 5'd4;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_tag", out_tag, 5'd31);
            check("hold_core_a", core_a, 32'h1234_5670);
        end
        check("hold_out_valid", out_valid, 1);
        check("hold_starts", start_count - s0, 1);
        ready_level = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check("fifth_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();
        check("hold_total_starts", start_count - s0, 6);

        // Flush while waiting on the core with two ops queued; a push in the flush cycle is dropped.
        core_lat = 15;
        sync();
        s0 = start_count;
        push_op(OP_FDIV, $urandom, $urandom, $urandom, 5'd7);
        wait_sig_start();
        sync();
        push_op(OP_FMADD, $urandom, $urandom, $urandom, 5'd8);
        push_op(OP_FSQRT, $urandom, $urandom, $urandom, 5'd9);
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd20; in_a = $urandom;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        any_v = 1'b0;
        for (int k = 0; k < 30; k++) begin @(negedge clk); any_v |= out_valid; end
        check("flush_no_result", any_v, 0);
        check("flush_starts", start_count - s0, 1);
        core_lat = 3;
        sync();
        push_op(OP_FSUB, $urandom, $urandom, $urandom, 5'd10);
        wait_drain();
        check("flush_next_starts", start_count - s0, 2);

        // Sticky flags, then clear coinciding with a handshake.
        core_lat = 2;
        sync();
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        push_op(OP_FSUB, 32'hABCD_0001, $urandom, $urandom, 5'd12);
        push_op(OP_FSUB, 32'h0000_1230, $urandom, $urandom, 5'd13);
        wait_drain();
        @(negedge clk);
        check("fflags_or", fflags, 5'h11);
        ready_level = 1'b0;
        sync();
        push_op(OP_FMUL, 32'h5555_0004, $urandom, $urandom, 5'd14);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        check("clr_hs_valid", out_valid, 1);
        ready_level = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        @(negedge clk);
        check("fflags_clr_hs", fflags, 5'h04);

        // Randomised traffic against the scoreboard.
        rand_ready = 1'b1;
        sync();
        for (int i = 0; i < 40; i++) begin
            core_lat = $urandom_range(1, 6);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            push_op(5'($urandom_range(0, 8)), $urandom, $urandom, $urandom, 5'($urandom));
        end
        wait_drain();
        rand_ready = 1'b0;

        // Asynchronous reset while the core is busy; its late done must be ignored.
        ready_level = 1'b1; core_lat = 12;
        sync();
        push_op(OP_FMADD, 32'h7777_0003, $urandom, $urandom, 5'd15);
        wait_sig_start();
        @(negedge clk);
        @(negedge clk);
        s0 = start_count;
        #1 reset = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_core_start", core_start, 0);
        check("arst_core_op", core_op, 0);
        check("arst_core_a", core_a, 0);
        check("arst_core_b", core_b, 0);
        check("arst_core_c", core_c, 0);
        check("arst_out_result", out_result, 0);
        check("arst_out_tag", out_tag, 0);
        check("arst_fflags", fflags, 0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        any_v = 1'b0;
        for (int k = 0; k < 25; k++) begin @(negedge clk); any_v |= out_valid; end
        check("arst_stray_done", any_v, 0);
        check("arst_no_start", start_count - s0, 0);
        core_lat = 2;
        sync();
        push_op(OP_FADD, $urandom, $urandom, $urandom, 5'd16);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
